dram_arbiter: RTL and testbench

- Shares one single-port data RAM (DRAM IP: address/clock/data/rden/wren/q) among the four cores.
- Each core raises a request carrying address, write flag and write data. The arbiter grants one core at a time in round-robin order and drives the RAM port.
- Returns read data plus a one-cycle acknowledge to the granted core.
- Sits between the core array and the DRAM instance in top, and replaces the per-core fixed wiring.

---
 rtl/dram_arb_pkg.sv | 25 ++
 rtl/rr_select.sv | 34 +++
 rtl/dram_arbiter.sv | 153 +++++++++++++++
 tb/tb_dram_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_arb_pkg.sv
// Shared definitions for the DRAM arbiter: state encoding, default widths,
// and a small width helper used by the arbiter and its selector.
package dram_arb_pkg;

    localparam int DEF_N_REQ  = 4;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_RD_LAT = 1;

    // Read latency is limited to 1..3, so the wait counter needs 2 bits.
    localparam int WAIT_CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    // Width of an index into n requesters (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin selector: picks the first set request bit
// searching upward from ptr+1, wrapping modulo N_REQ.
module rr_select
    import dram_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IDX_W = idx_width(DEF_N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] index
);

    logic             found;
    logic [IDX_W-1:0] cand_idx;

    // Walk the candidates in priority order; the first requesting one wins.
    always_comb begin
        grant    = '0;
        index    = '0;
        found    = 1'b0;
        cand_idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand_idx = IDX_W'((int'(ptr) + k) % N_REQ);
            if (!found && req[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                index           = cand_idx;
            end
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM among the cores.
// One transaction at a time: latch the winner, issue one strobe cycle,
// wait out the read latency, then pulse the winner's acknowledge.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [N_REQ-1:0]          i_we,
    input  logic [N_REQ*ADDR_W-1:0]   i_addr,
    input  logic [N_REQ*DATA_W-1:0]   i_wdata,
    output logic [N_REQ-1:0]          o_ack,
    output logic [DATA_W-1:0]         o_rdata,
    output logic [N_REQ-1:0]          o_grant,
    output logic [ADDR_W-1:0]         o_mem_addr,
    output logic [DATA_W-1:0]         o_mem_wdata,
    output logic                      o_mem_rden,
    output logic                      o_mem_wren,
    input  logic [DATA_W-1:0]         i_mem_q,
    output logic                      o_busy
);

    localparam int IDX_W = idx_width(N_REQ);
    localparam int CNT_W = WAIT_CNT_W;

    arb_state_t        state_reg, state_next;
    logic [IDX_W-1:0]  idx_reg,   idx_next;
    logic [N_REQ-1:0]  grant_reg, grant_next;
    logic              we_reg,    we_next;
    logic [ADDR_W-1:0] addr_reg,  addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [CNT_W-1:0]  cnt_reg,   cnt_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;
    logic [IDX_W-1:0]  ptr_reg,   ptr_next;

    logic [N_REQ-1:0]  sel_grant;
    logic [IDX_W-1:0]  sel_index;

    logic [ADDR_W-1:0] addr_arr  [N_REQ];
    logic [DATA_W-1:0] wdata_arr [N_REQ];

    // Unpack the per-core address and write-data buses.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = i_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = i_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_select #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .req   (i_req),
        .ptr   (ptr_reg),
        .grant (sel_grant),
        .index (sel_index)
    );

    // Next-state and latch logic for the transaction sequence.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        grant_next = grant_reg;
        we_next    = we_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        cnt_next   = cnt_reg;
        rdata_next = rdata_reg;
        ptr_next   = ptr_reg;

        case (state_reg)
            IDLE: begin
                if (|i_req) begin
                    idx_next   = sel_index;
                    grant_next = sel_grant;
                    we_next    = i_we[sel_index];
                    addr_next  = addr_arr[sel_index];
                    wdata_next = wdata_arr[sel_index];
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (we_reg) begin
                    state_next = DONE;
                end else begin
                    cnt_next   = CNT_W'(RD_LAT - 1);
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    rdata_next = i_mem_q;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            DONE: begin
                // The winner becomes lowest priority for the next round.
                ptr_next   = idx_reg;
                grant_next = '0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and latch registers; reset aborts any transaction in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            grant_reg <= '0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            cnt_reg   <= '0;
            rdata_reg <= '0;
            ptr_reg   <= IDX_W'(N_REQ - 1);
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            grant_reg <= grant_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            cnt_reg   <= cnt_next;
            rdata_reg <= rdata_next;
            ptr_reg   <= ptr_next;
        end
    end

    // RAM strobes exist only in ISSUE; the ack is suppressed while reset
    // is asserted so an aborted transaction never completes.
    assign o_mem_addr  = addr_reg;
    assign o_mem_wdata = wdata_reg;
    assign o_mem_rden  = (state_reg == ISSUE) && !we_reg;
    assign o_mem_wren  = (state_reg == ISSUE) &&  we_reg;
    assign o_grant     = grant_reg;
    assign o_ack       = ((state_reg == DONE) && !i_rst) ? grant_reg : '0;
    assign o_rdata     = rdata_reg;
    assign o_busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: a transaction-timeline model checks
// the RD_LAT=1 instance every cycle; directed literals pin the scenarios,
// and a second RD_LAT=3 instance covers the longer read latency.
module tb_dram_arbiter;

    localparam int L1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // RD_LAT=1 instance signals
    logic        rst;
    logic [3:0]  req, we;
    logic [63:0] addr;
    logic [31:0] wdata;
    logic [3:0]  ack, grant;
    logic [7:0]  rdata, mem_wdata, mem_q;
    logic [15:0] mem_addr;
    logic        mem_rden, mem_wren, busy;

    // RD_LAT=3 instance signals
    logic        rst3;
    logic [3:0]  req3, we3;
    logic [63:0] addr3;
    logic [31:0] wdata3;
    logic [3:0]  ack3, grant3;
    logic [7:0]  rdata3, mem_wdata3, mem_q3;
    logic [15:0] mem_addr3;
    logic        mem_rden3, mem_wren3, busy3;

    dram_arbiter #(.N_REQ(4), .ADDR_W(16), .DATA_W(8), .RD_LAT(1)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr),
        .i_wdata(wdata), .o_ack(ack), .o_rdata(rdata), .o_grant(grant),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_rden(mem_rden),
        .o_mem_wren(mem_wren), .i_mem_q(mem_q), .o_busy(busy)
    );

    dram_arbiter #(.N_REQ(4), .ADDR_W(16), .DATA_W(8), .RD_LAT(3)) u_dut3 (
        .i_clk(clk), .i_rst(rst3), .i_req(req3), .i_we(we3), .i_addr(addr3),
        .i_wdata(wdata3), .o_ack(ack3), .o_rdata(rdata3), .o_grant(grant3),
        .o_mem_addr(mem_addr3), .o_mem_wdata(mem_wdata3), .o_mem_rden(mem_rden3),
        .o_mem_wren(mem_wren3), .i_mem_q(mem_q3), .o_busy(busy3)
    );

    // Behavioural RAMs: load port for preloading, one-cycle and three-cycle reads.
    logic        ld_en;
    logic [15:0] ld_addr;
    logic [7:0]  ld_data;
    logic [7:0]  ram1 [65536];
    logic [7:0]  ram3 [65536];
    logic [7:0]  p1, p2;

    always @(posedge clk) begin
        if (ld_en) ram1[ld_addr] <= ld_data;
        else if (mem_wren) ram1[mem_addr] <= mem_wdata;
        if (mem_rden) mem_q <= ram1[mem_addr];
    end

    always @(posedge clk) begin
        if (ld_en) ram3[ld_addr] <= ld_data;
        else if (mem_wren3) ram3[mem_addr3] <= mem_wdata3;
        if (mem_rden3) p1 <= ram3[mem_addr3];
        p2     <= p1;
        mem_q3 <= p2;
    end

    // Counters
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model of the RD_LAT=1 instance
    logic [7:0]  mmem [65536];
    bit          m_valid = 0;
    bit          m_act;
    int          m_ptr, m_idx, m_off, m_len;
    bit          m_we;
    logic [15:0] m_addr;
    logic [7:0]  m_wdata, m_rdata;

    task automatic model_step();
        int  j;
        bit  found;
        if (rst) begin
            m_valid = 1; m_act = 0; m_ptr = 3; m_idx = 0; m_off = 0; m_len = 0;
            m_we = 0; m_addr = '0; m_wdata = '0; m_rdata = '0;
        end else if (m_valid) begin
            if (m_act) begin
                if (m_off == m_len - 1) begin
                    m_act = 0;
                    m_ptr = m_idx;
                end else begin
                    if (m_off == 0 && m_we) mmem[m_addr] = m_wdata;
                    m_off++;
                    if (m_off == m_len - 1 && !m_we) m_rdata = mmem[m_addr];
                end
            end else if (req != 4'b0000) begin
                found = 0;
                for (int k = 1; k <= 4; k++) begin
                    j = (m_ptr + k) % 4;
                    if (!found && req[j]) begin
                        found   = 1;
                        m_idx   = j;
                    end
                end
                m_we    = we[m_idx];
                m_addr  = addr[m_idx*16 +: 16];
                m_wdata = wdata[m_idx*8 +: 8];
                m_act   = 1;
                m_off   = 0;
                m_len   = m_we ? 2 : 2 + L1;
            end
        end
    endtask

    task automatic model_cmp();
        logic [3:0] oh;
        if (!m_valid) return;
        oh = 4'b0001 << m_idx;
        chk("m_busy",  busy,      m_act);
        chk("m_grant", grant,     m_act ? oh : 4'b0000);
        chk("m_ack",   ack,       (m_act && m_off == m_len - 1 && !rst) ? oh : 4'b0000);
        chk("m_rden",  mem_rden,  m_act && m_off == 0 && !m_we);
        chk("m_wren",  mem_wren,  m_act && m_off == 0 && m_we);
        chk("m_addr",  mem_addr,  m_addr);
        chk("m_wdata", mem_wdata, m_wdata);
        chk("m_rdata", rdata,     m_rdata);
    endtask

    // One clock cycle: advance model at the edge, compare just after, return at negedge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        model_cmp();
        @(negedge clk);
    endtask

    // Stimulus helpers
    bit   drop [4];
    int   log_core [8];
    int   log_lat  [8];
    logic [7:0] log_rd [8];
    int   rden_cnt, wren_cnt, idle_cnt, txn_no = 0;
    logic [15:0] rden_addr;

    task automatic set_req(input int core, input bit w, input logic [15:0] a,
                           input logic [7:0] d, input bit drop_on_ack);
        req[core]            = 1'b1;
        we[core]             = w;
        addr[core*16 +: 16]  = a;
        wdata[core*8 +: 8]   = d;
        drop[core]           = drop_on_ack;
    endtask

    task automatic run(input int n, input int budget);
        int k, got, idx;
        k = 0; got = 0; rden_cnt = 0; wren_cnt = 0; idle_cnt = 0; rden_addr = '0;
        while (got < n && k < budget) begin
            tick();
            k++;
            if (mem_rden) begin rden_cnt++; rden_addr = mem_addr; end
            if (mem_wren) wren_cnt++;
            if (!busy) idle_cnt++;
            if (ack != 4'b0000) begin
                idx = 0;
                for (int i = 0; i < 4; i++) if (ack[i]) idx = i;
                log_core[got] = idx;
                log_lat[got]  = k + 1;
                log_rd[got]   = rdata;
                $display("txn %0d: core=%0d we=%0d lat=%0d rdata=%02h", txn_no, idx, we[idx], k + 1, rdata);
                txn_no++;
                if (drop[idx]) req[idx] = 1'b0;
                got++;
            end
        end
        chk("ack_count", got, n);
    endtask

    task automatic load(input logic [15:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d; mmem[a] = d;
        tick();
    endtask

    initial begin
        int k, lat3, wait3, bad3, rden3_cnt;
        logic [7:0] rd3;
        rst = 1; req = '0; we = '0; addr = '0; wdata = '0;
        rst3 = 1; req3 = '0; we3 = '0; addr3 = '0; wdata3 = '0;
        ld_en = 0; ld_addr = '0; ld_data = '0;
        for (int i = 0; i < 4; i++) drop[i] = 1;

        tick();
        tick();
        load(16'h0010, 8'h5A);
        load(16'h0020, 8'hA5);
        load(16'h0030, 8'h3C);
        load(16'h0040, 8'h96);
        load(16'hFFFF, 8'h81);
        ld_en = 0;

        // Reset state
        chk("rst_grant", grant, 4'b0000);
        chk("rst_ack",   ack,   4'b0000);
        chk("rst_busy",  busy,  1'b0);
        chk("rst_rden",  mem_rden, 1'b0);
        chk("rst_wren",  mem_wren, 1'b0);
        chk("rst_addr",  mem_addr, 16'h0000);
        chk("rst_rdata", rdata, 8'h00);
        rst = 0;
        tick();

        // Single read, core1 @0x0010
        set_req(1, 0, 16'h0010, 8'h00, 1);
        run(1, 20);
        chk("rd1_core", log_core[0], 1);
        chk("rd1_lat",  log_lat[0], 4);
        chk("rd1_data", log_rd[0], 8'h5A);
        chk("rd1_rden_cycles", rden_cnt, 1);
        chk("rd1_rden_addr", rden_addr, 16'h0010);
        chk("rd1_wren_cycles", wren_cnt, 0);
        tick();

        // Write then read back, core2 @0x0100
        set_req(2, 1, 16'h0100, 8'hC3, 1);
        run(1, 20);
        chk("wr2_core", log_core[0], 2);
        chk("wr2_lat",  log_lat[0], 3);
        chk("wr2_wren_cycles", wren_cnt, 1);
        chk("wr2_rden_cycles", rden_cnt, 0);
        tick();
        set_req(2, 0, 16'h0100, 8'h00, 1);
        run(1, 20);
        chk("rd2_core", log_core[0], 2);
        chk("rd2_data", log_rd[0], 8'hC3);
        chk("rd2_lat",  log_lat[0], 4);

        // All four at once after reset: order 0,1,2,3, one IDLE gap each
        rst = 1;
        tick();
        rst = 0;
        set_req(0, 0, 16'h0010, 8'h00, 1);
        set_req(1, 0, 16'h0020, 8'h00, 1);
        set_req(2, 0, 16'h0030, 8'h00, 1);
        set_req(3, 0, 16'h0040, 8'h00, 1);
        run(4, 60);
        chk("all_core0", log_core[0], 0);
        chk("all_core1", log_core[1], 1);
        chk("all_core2", log_core[2], 2);
        chk("all_core3", log_core[3], 3);
        chk("all_data0", log_rd[0], 8'h5A);
        chk("all_data3", log_rd[3], 8'h96);
        chk("all_lat0",  log_lat[0], 4);
        chk("all_lat3",  log_lat[3], 16);
        chk("all_idle_gaps", idle_cnt, 3);
        tick();

        // Fairness: core0 holds forever, core3 asks once
        set_req(0, 1, 16'h0200, 8'h11, 0);
        set_req(3, 0, 16'h0010, 8'h00, 1);
        run(3, 40);
        req[0] = 1'b0;
        chk("fair_first",  log_core[0], 0);
        chk("fair_second", log_core[1], 3);
        chk("fair_third",  log_core[2], 0);
        chk("fair_data3",  log_rd[1], 8'h5A);
        tick();

        // Reset during WAIT of a core1 read
        set_req(1, 0, 16'h0020, 8'h00, 1);
        tick();
        chk("abort_issue_rden",  mem_rden, 1'b1);
        chk("abort_issue_grant", grant, 4'b0010);
        tick();
        chk("abort_wait_rden", mem_rden, 1'b0);
        chk("abort_wait_addr", mem_addr, 16'h0020);
        rst = 1;
        tick();
        chk("abort_grant", grant, 4'b0000);
        chk("abort_ack",   ack,   4'b0000);
        chk("abort_busy",  busy,  1'b0);
        chk("abort_addr",  mem_addr, 16'h0000);
        chk("abort_rdata", rdata, 8'h00);
        req[1] = 1'b0;
        tick();
        chk("abort_no_ack", ack, 4'b0000);
        rst = 0;
        set_req(2, 0, 16'h0040, 8'h00, 1);
        set_req(0, 0, 16'h0030, 8'h00, 1);
        run(2, 30);
        chk("post_abort_first",  log_core[0], 0);
        chk("post_abort_second", log_core[1], 2);
        chk("post_abort_data0",  log_rd[0], 8'h3C);
        tick();

        // RD_LAT=3 instance: core0 read @0xFFFF
        chk("l3_rst_busy", busy3, 1'b0);
        chk("l3_rst_ack",  ack3, 4'b0000);
        rst3 = 0;
        req3 = 4'b0001; we3 = 4'b0000; addr3[15:0] = 16'hFFFF;
        k = 0; lat3 = 0; wait3 = 0; bad3 = 0; rden3_cnt = 0; rd3 = '0;
        while (lat3 == 0 && k < 20) begin
            tick();
            k++;
            if (busy3 && !mem_rden3 && !mem_wren3 && ack3 == 4'b0000) begin
                wait3++;
                if (mem_addr3 != 16'hFFFF) bad3++;
            end
            if (mem_rden3) rden3_cnt++;
            if (ack3 != 4'b0000) begin
                lat3 = k + 1;
                rd3  = rdata3;
                chk("l3_ack_onehot", ack3, 4'b0001);
                $display("txn %0d: l3 core=0 we=0 lat=%0d rdata=%02h", txn_no, lat3, rd3);
                txn_no++;
                req3 = 4'b0000;
            end
        end
        chk("l3_lat",   lat3, 6);
        chk("l3_data",  rd3, 8'h81);
        chk("l3_rden_cycles", rden3_cnt, 1);
        chk("l3_wait_no_strobe", wait3, 3);
        chk("l3_addr_held", bad3, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
